axi_ram_slave: RTL and testbench

AXI3 burst responder that backs a byte-addressable word RAM and answers the CPU bridge's 32-bit AXI master port, including the 16-beat cache-line bursts (512-bit lines). It serves as the memory end of the bus in simulation benches and standalone FPGA bring-up when no SoC RAM controller is present. It runs one read burst and one write burst concurrently on independent channels, with at most one outstanding transaction per direction.

---
 rtl/axi_ram_slave_pkg.sv | 37 +++
 rtl/axi_ram_slave_ram.sv | 38 +++
 rtl/axi_ram_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI3 codes, channel FSM states and the burst address sequencer
// used by both the read and the write side of axi_ram_slave.
package axi_ram_slave_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
      return (burst == 2'b11) || ((burst == AXI_BURST_WRAP) && !wrap_len_ok(len));
   endfunction

   // Illegal WRAP lengths and the reserved code both fall through to INCR.
   function automatic logic [31:0] next_addr(input logic [1:0] burst, input logic [7:0] len,
                                             input logic [31:0] addr);
      logic [31:0] inc;
      logic [31:0] mask;
      inc  = addr + 32'd4;
      mask = ((({24'd0, len}) + 32'd1) << 2) - 32'd1;
      if (burst == AXI_BURST_FIXED)
         return addr;
      else if ((burst == AXI_BURST_WRAP) && wrap_len_ok(len))
         return (addr & ~mask) | (inc & mask);
      else
         return inc;
   endfunction

endpackage

// File: rtl/axi_ram_slave_ram.sv
// Simple dual-port word RAM: registered read port, byte-enabled write port.
// On a same-address collision the read port returns the old word.
module sdp_ram_be #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            wr_be
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [0:DEPTH-1];
         logic [7:0] rd_q;

         // Only the output register is reset; the array keeps its contents.
         always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi])
               mem[wr_addr] <= wr_data[gi*8 +: 8];
            if (srst)
               rd_q <= 8'd0;
            else if (rd_en)
               rd_q <= mem[rd_addr];
         end

         assign rd_data[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 burst slave in front of a byte-enabled word RAM; independent read and
// write FSMs, one outstanding transaction per direction.
module axi_ram_slave
   import axi_ram_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   rd_state_t   rd_state_q, rd_state_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [1:0]  rresp_q, rresp_d, rburst_q, rburst_d;
   logic [3:0]  rid_q, rid_d;
   logic [31:0] raddr_q, raddr_d, raddr_nx;
   logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;

   wr_state_t   wr_state_q, wr_state_d;
   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic        werr_q, werr_d, beat_err;
   logic [1:0]  bresp_q, bresp_d, wburst_q, wburst_d;
   logic [3:0]  bid_q, bid_d;
   logic [31:0] waddr_q, waddr_d;
   logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;

   logic                  ram_rd_en, ram_we;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic                  unused_sizes;

   assign unused_sizes = ^{arsize, awsize};

   always_comb begin
      rd_state_d  = rd_state_q;
      arready_d   = arready_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      rresp_d     = rresp_q;
      rburst_d    = rburst_q;
      rid_d       = rid_q;
      raddr_d     = raddr_q;
      rlen_d      = rlen_q;
      rcnt_d      = rcnt_q;
      ram_rd_en   = 1'b0;
      raddr_nx    = next_addr(rburst_q, rlen_q, raddr_q);
      ram_rd_addr = raddr_q[ADDR_WIDTH+1:2];
      unique case (rd_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arvalid && arready_q) begin
               rid_d      = arid;
               raddr_d    = araddr;
               rlen_d     = arlen;
               rburst_d   = arburst;
               rcnt_d     = 8'd0;
               rresp_d    = burst_err(arburst, arlen) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               arready_d  = 1'b0;
               rd_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            ram_rd_en  = 1'b1;
            rvalid_d   = 1'b1;
            rlast_d    = (rlen_q == 8'd0);
            rd_state_d = R_DATA;
         end
         R_DATA: begin
            // The next beat is fetched on the handshake so the RAM output
            // stays frozen while the master stalls.
            if (rready) begin
               if (rlast_q) begin
                  rvalid_d   = 1'b0;
                  rlast_d    = 1'b0;
                  arready_d  = 1'b1;
                  rd_state_d = R_IDLE;
               end else begin
                  raddr_d     = raddr_nx;
                  ram_rd_en   = 1'b1;
                  ram_rd_addr = raddr_nx[ADDR_WIDTH+1:2];
                  rcnt_d      = rcnt_q + 8'd1;
                  rlast_d     = (rcnt_q + 8'd1 == rlen_q);
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      bid_d      = bid_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wburst_d   = wburst_q;
      wcnt_d     = wcnt_q;
      werr_d     = werr_q;
      ram_we     = 1'b0;
      beat_err   = werr_q | (wlast != (wcnt_q == wlen_q));
      unique case (wr_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (awvalid && awready_q) begin
               bid_d      = awid;
               waddr_d    = awaddr;
               wlen_d     = awlen;
               wburst_d   = awburst;
               wcnt_d     = 8'd0;
               werr_d     = burst_err(awburst, awlen);
               awready_d  = 1'b0;
               wready_d   = 1'b1;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               ram_we = 1'b1;
               werr_d = beat_err;
               if (wcnt_q == wlen_q) begin
                  wready_d   = 1'b0;
                  bvalid_d   = 1'b1;
                  bresp_d    = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  wr_state_d = W_RESP;
               end else begin
                  wcnt_d  = wcnt_q + 8'd1;
                  waddr_d = next_addr(wburst_q, wlen_q, waddr_q);
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rresp_q    <= AXI_RESP_OKAY;
         rburst_q   <= AXI_BURST_INCR;
         rid_q      <= 4'd0;
         raddr_q    <= 32'd0;
         rlen_q     <= 8'd0;
         rcnt_q     <= 8'd0;
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= AXI_RESP_OKAY;
         bid_q      <= 4'd0;
         waddr_q    <= 32'd0;
         wlen_q     <= 8'd0;
         wburst_q   <= AXI_BURST_INCR;
         wcnt_q     <= 8'd0;
         werr_q     <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rresp_q    <= rresp_d;
         rburst_q   <= rburst_d;
         rid_q      <= rid_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rcnt_q     <= rcnt_d;
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         bid_q      <= bid_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wburst_q   <= wburst_d;
         wcnt_q     <= wcnt_d;
         werr_q     <= werr_d;
      end
   end

   sdp_ram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk     (clk),
      .srst    (rst),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (rdata),
      .wr_en   (ram_we && !rst),
      .wr_addr (waddr_q[ADDR_WIDTH+1:2]),
      .wr_data (wdata),
      .wr_be   (wstrb)
   );

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rresp   = rresp_q;
   assign rid     = rid_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign bid     = bid_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed and randomized bursts against a word-array model of the RAM with
// burst addresses computed arithmetically from start, length and type.
module tb_axi_ram_slave;
   localparam int AW    = 14;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arid, awid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   int total = 0;
   int bad   = 0;
   logic [31:0] mem_m [int];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] last_rdata;

   always #5 clk = ~clk;

   axi_ram_slave #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic legal_wrap(input int len);
      return (len == 1) || (len == 3) || (len == 7) || (len == 15);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [1:0] burst, input int len);
      return ((burst == 2'b11) || (burst == 2'b10 && !legal_wrap(len))) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] start, input int len,
                                            input logic [1:0] burst, input int beat);
      int unsigned bytes;
      logic [31:0] base;
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && legal_wrap(len)) begin
         bytes = (len + 1) * 4;
         base  = start - (start % bytes);
         return base + ((start - base + 4 * beat) % bytes);
      end
      return start + 4 * beat;
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int wlast_beat, input int bhold, input logic [3:0] id);
      int n;
      int k;
      logic [31:0] a;
      logic [31:0] w;
      chk("wready_before_aw", wready, 0);
      awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst; awsize = 3'd2; awvalid = 1;
      n = 0;
      while (awready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("aw_wait", {31'd0, awready}, 1);
      @(posedge clk); #1;
      awvalid = 0;
      chk("wready_lat", wready, 1);
      chk("awready_drop", awready, 0);
      for (int i = 0; i <= len; i++) begin
         a = exp_addr(addr, len, burst, i);
         k = widx(a);
         if (!mem_m.exists(k)) ws[i] = 4'hF;
         wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_beat);
         n = 0;
         while (wready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
         chk("w_wait", {31'd0, wready}, 1);
         @(posedge clk); #1;
         w = mem_m.exists(k) ? mem_m[k] : 32'd0;
         for (int b = 0; b < 4; b++)
            if (ws[i][b]) w[b*8 +: 8] = wd[i][b*8 +: 8];
         mem_m[k] = w;
      end
      wvalid = 0; wlast = 0;
      chk("bvalid_lat", bvalid, 1);
      chk("bresp", bresp, (wlast_beat != len) ? 2'b10 : exp_resp(burst, len));
      chk("bid", bid, id);
      chk("wready_off", wready, 0);
      bready = 0;
      for (int j = 0; j < bhold; j++) begin
         @(posedge clk); #1;
         chk("bvalid_hold", bvalid, 1);
         chk("awready_hold", awready, 0);
      end
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      chk("bvalid_clr", bvalid, 0);
      chk("awready_back", awready, 1);
      $display("txn write addr=%08h len=%0d burst=%0d id=%0d bresp=%0d", addr, len, burst, id, bresp);
   endtask

   // rmode: 0 = rready high, 1 = toggling, 2 = random. abort_at >= 0 pulses rst at that beat.
   task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int rmode, input int abort_at, input logic [3:0] id);
      int n;
      int b;
      int cyc;
      logic r;
      logic hs;
      arid = id; araddr = addr; arlen = len[7:0]; arburst = burst; arsize = 3'd2; arvalid = 1;
      n = 0;
      while (arready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("ar_wait", {31'd0, arready}, 1);
      @(posedge clk); #1;
      arvalid = 0;
      chk("rvalid_t1", rvalid, 0);
      chk("arready_drop", arready, 0);
      @(posedge clk); #1;
      chk("rvalid_t2", rvalid, 1);
      b = 0; cyc = 0;
      while (b <= len && cyc < 300) begin
         if (b == abort_at) begin
            rst = 1; rready = 0;
            @(posedge clk); #1;
            chk("rvalid_after_rst", rvalid, 0);
            @(posedge clk); #1;
            rst = 0;
            chk("arready_rst_c1", arready, 0);
            chk("awready_rst_c1", awready, 0);
            @(posedge clk); #1;
            chk("arready_rst_c2", arready, 1);
            $display("txn read-abort addr=%08h len=%0d at beat %0d", addr, len, b);
            return;
         end
         if (rmode == 0) r = 1'b1;
         else if (rmode == 1) r = (cyc % 2 == 1);
         else r = 1'($urandom_range(0, 1));
         rready = r;
         if (rmode == 0) chk("rvalid_cont", rvalid, 1);
         hs = (rvalid === 1'b1) && r;
         if (rvalid === 1'b1) begin
            chk("rdata", rdata, mem_m[widx(exp_addr(addr, len, burst, b))]);
            chk("rlast", rlast, (b == len));
            chk("rresp", rresp, exp_resp(burst, len));
            chk("rid", rid, id);
            last_rdata = rdata;
         end
         @(posedge clk); #1;
         if (hs) b++;
         cyc++;
      end
      rready = 0;
      chk("r_beats", b, len + 1);
      chk("rvalid_end", rvalid, 0);
      chk("arready_end", arready, 1);
      $display("txn read addr=%08h len=%0d burst=%0d id=%0d last=%08h", addr, len, burst, id, last_rdata);
   endtask

   initial begin
      logic [31:0] ra;
      int rl;
      logic [1:0] rb;
      int lens [4] = '{1, 3, 7, 15};
      rst = 1;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", arready, 0);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", {rresp, bresp}, 0);
      chk("rst_ids", {rid, bid}, 0);
      rst = 0;
      chk("post_rst_c1", {arready, awready}, 0);
      @(posedge clk); #1;
      chk("post_rst_c2", {arready, awready}, 2'b11);

      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      axi_write(32'h100, 0, 2'b01, 0, 0, 4'h3);
      axi_read(32'h100, 0, 2'b01, 0, -1, 4'h5);

      for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
      axi_write(32'h1000, 15, 2'b01, 15, 0, 4'h1);
      axi_read(32'h1000, 15, 2'b01, 0, -1, 4'h2);

      wd[0] = 32'h11223344; ws[0] = 4'hF;
      axi_write(32'h300, 0, 2'b01, 0, 0, 4'h0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      axi_write(32'h300, 0, 2'b01, 0, 0, 4'h0);
      axi_read(32'h300, 0, 2'b01, 0, -1, 4'h0);
      chk("partial_word", last_rdata, 32'h11BB33DD);

      wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      axi_write(32'h208, 3, 2'b10, 3, 0, 4'h7);
      axi_read(32'h200, 3, 2'b01, 0, -1, 4'h7);
      axi_read(32'h200, 2, 2'b00, 0, -1, 4'h8);
      chk("fixed_word", last_rdata, 32'hC);

      axi_read(32'h1000, 7, 2'b01, 1, -1, 4'h9);
      for (int i = 0; i < 2; i++) begin wd[i] = 32'h5A5A0000 + i; ws[i] = 4'hF; end
      axi_write(32'h500, 1, 2'b01, 1, 5, 4'hA);

      for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0 + i; ws[i] = 4'hF; end
      axi_write(32'h600, 3, 2'b01, 2, 0, 4'hB);
      axi_write(32'h700, 1, 2'b11, 1, 0, 4'hC);
      axi_read(32'h700, 1, 2'b11, 0, -1, 4'hC);
      for (int i = 0; i < 3; i++) begin wd[i] = 32'hF0 + i; ws[i] = 4'hF; end
      axi_write(32'h804, 2, 2'b10, 2, 0, 4'hD);
      axi_read(32'h804, 2, 2'b10, 2, -1, 4'hD);

      for (int t = 0; t < 12; t++) begin
         ra = 32'h4000 + {$urandom_range(0, 255), 2'b00};
         rb = 2'($urandom_range(0, 2));
         rl = (rb == 2'b10) ? lens[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
         axi_write(ra, rl, rb, rl, int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
         axi_read(ra, rl, rb, 2, -1, 4'($urandom_range(0, 15)));
      end

      axi_read(32'h1000, 15, 2'b01, 0, 5, 4'h6);
      axi_read(32'h1000, 15, 2'b01, 1, -1, 4'h6);
      axi_read(32'h208, 3, 2'b10, 0, -1, 4'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
